// File: rtl/match_controller.sv
// Round/match sequencer for the tug-of-war game: gates the playfield, keeps score, drives the level operand and digits.
// Optional difficulty ramp enabled by defining MATCH_DIFFICULTY_RAMP_EN.
module match_controller #(
    parameter int unsigned WIN_SCORE   = 3,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [8:0]  BASE_LEVEL  = 9'd256,
    parameter logic [8:0]  LEVEL_STEP  = 9'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       win_l,
    input  logic       win_r,
    output logic       field_reset,
    output logic       play_en,
    output logic [8:0] level,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r,
    output logic       match_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLAY,
        ST_ROUND_END,
        ST_MATCH_OVER
    } state_t;

    localparam int unsigned CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]  WIN_TARGET = 3'(WIN_SCORE);

    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic [8:0]    level_q, level_d;
    logic          winner_q, winner_d;
    logic          field_reset_q, field_reset_d;
    logic          play_en_q, play_en_d;
    logic          match_over_q, match_over_d;
    logic [6:0]    hex_l_q, hex_l_d, hex_r_q, hex_r_d;

`ifdef MATCH_DIFFICULTY_RAMP_EN
    logic [9:0] level_sum;
    assign level_sum = {1'b0, level_q} + {1'b0, LEVEL_STEP};
`else
    logic unused_level_step;
    assign unused_level_step = ^LEVEL_STEP;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        level_d   = level_q;
        winner_d  = winner_q;
        case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    score_l_d = 3'd0;
                    score_r_d = 3'd0;
                    level_d   = BASE_LEVEL;
                end
            end
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY: begin
                // simultaneous wins cancel out and are ignored
                if (win_l ^ win_r) begin
                    state_d  = ST_ROUND_END;
                    cnt_d    = HOLD_LOAD;
                    winner_d = win_r;
                    if (win_r) begin
                        score_r_d = score_r_q + 3'd1;
`ifdef MATCH_DIFFICULTY_RAMP_EN
                        level_d = level_sum[9] ? 9'd511 : level_sum[8:0];
`endif
                    end else begin
                        score_l_d = score_l_q + 3'd1;
                    end
                end
            end
            ST_ROUND_END: begin
                if (cnt_q == '0) begin
                    state_d = (score_l_q == WIN_TARGET || score_r_q == WIN_TARGET)
                              ? ST_MATCH_OVER : ST_CLEAR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifndef MATCH_DIFFICULTY_RAMP_EN
        level_d = BASE_LEVEL;
`endif
        field_reset_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_MATCH_OVER);
        play_en_d     = (state_d == ST_PLAY);
        match_over_d  = (state_d == ST_MATCH_OVER);
        hex_l_d       = seg7(score_l_d);
        hex_r_d       = seg7(score_r_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            score_l_q     <= 3'd0;
            score_r_q     <= 3'd0;
            level_q       <= BASE_LEVEL;
            winner_q      <= 1'b0;
            field_reset_q <= 1'b1;
            play_en_q     <= 1'b0;
            match_over_q  <= 1'b0;
            hex_l_q       <= 7'b1000000;
            hex_r_q       <= 7'b1000000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            level_q       <= level_d;
            winner_q      <= winner_d;
            field_reset_q <= field_reset_d;
            play_en_q     <= play_en_d;
            match_over_q  <= match_over_d;
            hex_l_q       <= hex_l_d;
            hex_r_q       <= hex_r_d;
        end
    end

    assign field_reset = field_reset_q;
    assign play_en     = play_en_q;
    assign level       = level_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign hex_l       = hex_l_q;
    assign hex_r       = hex_r_q;
    assign match_over  = match_over_q;
    assign winner      = winner_q;

endmodule
